// File: rtl/spinn_pkt_arbiter.sv
// spinn_pkt_arbiter: shares one 72-bit SpiNNaker packet link between NUM_SRC
// producers. Round-robin with a bounded burst per source (or fixed priority),
// per-source enable mask, flush of the held packet, and a registered
// valid/ready output stage.
// Optional per-source saturating packet counters: define PKT_ARB_STATS_EN.
module spinn_pkt_arbiter #(
  parameter int NUM_SRC   = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  fixed_prio,
  input  logic [NUM_SRC-1:0]    src_en,
  input  logic [72*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]    src_vld,
  output logic [NUM_SRC-1:0]    src_rdy,
  output logic [71:0]           opkt_data,
  output logic                  opkt_vld,
  input  logic                  opkt_rdy,
  output logic [2:0]            last_grant,
  output logic [7:0]            burst_cnt,
  input  logic [2:0]            stat_sel,
  output logic [15:0]           stat_cnt
);

  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);
  localparam logic [2:0] LAST_SRC  = 3'(NUM_SRC - 1);

  logic [NUM_SRC-1:0] eligible;
  logic               free;
  logic               load;
  logic               last_elig;
  logic               lock;
  logic [2:0]         sel;
  logic [71:0]        sel_data;

  assign eligible = src_vld & src_en & {NUM_SRC{enable}};
  assign free     = ~opkt_vld | opkt_rdy;
  assign load     = free & (|eligible) & ~flush;

  // eligibility of the previous winner (last_grant always holds a legal index)
  always_comb begin
    last_elig = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      if (last_grant == 3'(i)) last_elig = eligible[i];
  end

  assign lock = last_elig & (burst_cnt < BURST_MAX) & ~fixed_prio;

  // winner select; loops run backwards so the first hit in scan order wins
  always_comb begin
    sel = last_grant;
    if (fixed_prio) begin
      for (int i = NUM_SRC - 1; i >= 0; i--)
        if (eligible[i]) sel = 3'(i);
    end else if (!lock) begin
      for (int k = NUM_SRC; k >= 1; k--)
        for (int j = 0; j < NUM_SRC; j++)
          if (eligible[j] && (((int'(last_grant) + k) % NUM_SRC) == j)) sel = 3'(j);
    end
  end

  // one-hot handshake back to the winner, and the winner's packet
  always_comb begin
    src_rdy  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (sel == 3'(i)) begin
        src_rdy[i] = load;
        sel_data   = src_data[72*i +: 72];
      end
  end

  // output register and burst tracking; rst beats flush, flush beats load
  always_ff @(posedge clk) begin
    if (rst) begin
      opkt_vld   <= 1'b0;
      opkt_data  <= '0;
      last_grant <= LAST_SRC;
      burst_cnt  <= '0;
    end else if (flush) begin
      opkt_vld  <= 1'b0;
      burst_cnt <= '0;
    end else if (load) begin
      opkt_vld  <= 1'b1;
      opkt_data <= sel_data;
      if (sel == last_grant) begin
        // wrap to 1 only happens on a sole-source re-grant after a full burst
        burst_cnt <= (burst_cnt < BURST_MAX) ? burst_cnt + 8'd1 : 8'd1;
      end else begin
        last_grant <= sel;
        burst_cnt  <= 8'd1;
      end
    end else if (opkt_vld && opkt_rdy) begin
      opkt_vld <= 1'b0;
    end
  end

`ifdef PKT_ARB_STATS_EN
  logic [15:0] stat_q [NUM_SRC];

  // saturating per-source load counters; flush leaves them alone
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) stat_q[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < NUM_SRC; i++)
        if (sel == 3'(i) && stat_q[i] != 16'hFFFF) stat_q[i] <= stat_q[i] + 16'd1;
    end
  end

  // counter readback; selects beyond NUM_SRC read as zero
  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (stat_sel == 3'(i)) stat_cnt = stat_q[i];
  end
`else
  logic stat_sel_unused;
  assign stat_sel_unused = ^stat_sel;
  assign stat_cnt        = 16'h0000;
`endif

endmodule
